// File: rtl/dht11_pkg.sv
// dht11_pkg: encodings and timing constants for the DHT11 single-wire
// protocol, shared by the responder (dht11_responder) and the host
// (dht11_sensor).
//   - FSM state encodings 0..8 (exposed on state_dbg)
//   - phase lengths in microseconds
//   - frame bit count
//   - dht11_chk(): 8-bit wrapping checksum of the four payload bytes
package dht11_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_HOST_LOW = 4'd1;
    localparam logic [3:0] S_HOST_REL = 4'd2;
    localparam logic [3:0] S_ACK_LOW  = 4'd3;
    localparam logic [3:0] S_ACK_HIGH = 4'd4;
    localparam logic [3:0] S_BIT_LOW  = 4'd5;
    localparam logic [3:0] S_BIT_HIGH = 4'd6;
    localparam logic [3:0] S_END_LOW  = 4'd7;
    localparam logic [3:0] S_RELEASE  = 4'd8;

    localparam int unsigned HOST_REL_US = 30;
    localparam int unsigned ACK_LOW_US  = 80;
    localparam int unsigned ACK_HIGH_US = 80;
    localparam int unsigned BIT_LOW_US  = 50;
    localparam int unsigned BIT0_HIGH_US = 26;
    localparam int unsigned BIT1_HIGH_US = 70;
    localparam int unsigned END_LOW_US  = 50;

    localparam logic [5:0] BIT_COUNT = 6'd40;

    function automatic logic [7:0] dht11_chk(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/dht11_us_tick.sv
// dht11_us_tick: free-running divider, one-clock tick every TICK_DIV clocks.
//   clk  : clock
//   rst  : synchronous active-high reset (restarts the divider)
//   tick : 1-clock pulse per microsecond
module dht11_us_tick #(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [31:0] cnt;
    logic        wrap;

    assign wrap = (cnt == TICK_DIV - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= wrap ? '0 : cnt + 32'd1;
            tick <= wrap;
        end
    end

endmodule

// File: rtl/dht11_responder.sv
// dht11_responder: DHT11 sensor emulator (responder side of the single-wire bus).
// Detects a host start pulse (>= START_MIN_US low), answers with an 80/80 us
// acknowledge and a 40-bit MSB-first frame {hum_int, hum_dec, temp_int,
// temp_dec, chk}.
//   clk, rst          : clock, synchronous active-high reset
//   dht11_io          : open-drain bus, driven only to 0 or z
//   hum_*, temp_*     : payload bytes, captured on ACK_LOW entry
//   chk_corrupt       : (DHT11_RESP_CHKERR_EN only) flips checksum bit 0
//   busy              : high from start acceptance until return to IDLE
//   frame_done        : one-clock pulse on END_LOW -> RELEASE
//   state_dbg         : current FSM state encoding
// Optional feature macro: DHT11_RESP_CHKERR_EN
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned START_MIN_US = 18000
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire        dht11_io,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_RESP_CHKERR_EN
    input  logic       chk_corrupt,
`endif
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] state_dbg
);

    localparam int unsigned TICK_DIV = CLK_FREQ_HZ / 1_000_000;

    logic        tick;
    logic        io_meta, io_s;
    logic [3:0]  state;
    logic [31:0] low_cnt;
    logic [31:0] phase_cnt;
    logic [31:0] phase_len;
    logic        phase_done;
    logic [39:0] shreg;
    logic [5:0]  bit_cnt;
    logic        drv_low;
    logic [7:0]  chk;

    dht11_us_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign dht11_io = drv_low ? 1'b0 : 1'bz;

    assign drv_low   = (state == S_ACK_LOW) || (state == S_BIT_LOW) || (state == S_END_LOW);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

`ifdef DHT11_RESP_CHKERR_EN
    assign chk = dht11_chk(hum_int, hum_dec, temp_int, temp_dec) ^ {7'd0, chk_corrupt};
`else
    assign chk = dht11_chk(hum_int, hum_dec, temp_int, temp_dec);
`endif

    // Timed phases are measured in clocks from state entry, so each lasts
    // exactly N*TICK_DIV clocks regardless of the free-running tick phase.
    always_comb begin
        phase_len = 32'd1;
        case (state)
            S_HOST_REL: phase_len = HOST_REL_US * TICK_DIV;
            S_ACK_LOW:  phase_len = ACK_LOW_US * TICK_DIV;
            S_ACK_HIGH: phase_len = ACK_HIGH_US * TICK_DIV;
            S_BIT_LOW:  phase_len = BIT_LOW_US * TICK_DIV;
            S_BIT_HIGH: phase_len = (shreg[39] ? BIT1_HIGH_US : BIT0_HIGH_US) * TICK_DIV;
            S_END_LOW:  phase_len = END_LOW_US * TICK_DIV;
            default:    phase_len = 32'd1;
        endcase
    end

    assign phase_done = (phase_cnt == phase_len - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            io_meta <= 1'b1;
            io_s    <= 1'b1;
        end else begin
            io_meta <= dht11_io;
            io_s    <= io_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            low_cnt    <= '0;
            phase_cnt  <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            phase_cnt  <= phase_cnt + 32'd1;
            case (state)
                S_IDLE: begin
                    if (io_s)
                        low_cnt <= '0;
                    else if (tick)
                        low_cnt <= low_cnt + 32'd1;
                    if (low_cnt >= START_MIN_US) begin
                        state     <= S_HOST_LOW;
                        low_cnt   <= '0;
                        phase_cnt <= '0;
                    end
                end
                S_HOST_LOW: begin
                    if (io_s) begin
                        state     <= S_HOST_REL;
                        phase_cnt <= '0;
                    end
                end
                S_HOST_REL: begin
                    if (phase_done) begin
                        state     <= S_ACK_LOW;
                        phase_cnt <= '0;
                        shreg     <= {hum_int, hum_dec, temp_int, temp_dec, chk};
                        bit_cnt   <= '0;
                    end
                end
                S_ACK_LOW: begin
                    if (phase_done) begin
                        state     <= S_ACK_HIGH;
                        phase_cnt <= '0;
                    end
                end
                S_ACK_HIGH: begin
                    if (phase_done) begin
                        state     <= S_BIT_LOW;
                        phase_cnt <= '0;
                    end
                end
                S_BIT_LOW: begin
                    if (phase_done) begin
                        state     <= S_BIT_HIGH;
                        phase_cnt <= '0;
                    end
                end
                S_BIT_HIGH: begin
                    if (phase_done) begin
                        shreg     <= {shreg[38:0], 1'b0};
                        bit_cnt   <= bit_cnt + 6'd1;
                        phase_cnt <= '0;
                        state     <= (bit_cnt == BIT_COUNT - 6'd1) ? S_END_LOW : S_BIT_LOW;
                    end
                end
                S_END_LOW: begin
                    if (phase_done) begin
                        state      <= S_RELEASE;
                        phase_cnt  <= '0;
                        frame_done <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (io_s) begin
                        state     <= S_IDLE;
                        phase_cnt <= '0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    phase_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: directed bench for dht11_responder, run at 2 MHz
// (TICK_DIV = 2) with a 200 us start threshold so frames stay short.
// Bus timings are measured in clocks sampled on the falling edge.
module tb_dht11_responder;

    localparam int unsigned CLK_HZ = 2_000_000;
    localparam int unsigned START_US = 200;
    localparam int TD = 2;  // clocks per us

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_low = 1'b0;
    logic [7:0] hum_int = '0, hum_dec = '0, temp_int = '0, temp_dec = '0;
    logic       chk_corrupt = 1'b0;
    logic       busy, frame_done;
    logic [3:0] state_dbg;
    wire        dht_bus;

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0;

    pullup (dht_bus);
    assign dht_bus = host_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    dht11_responder #(.CLK_FREQ_HZ(CLK_HZ), .START_MIN_US(START_US)) dut (
        .clk        (clk),
        .rst        (rst),
        .dht11_io   (dht_bus),
        .hum_int    (hum_int),
        .hum_dec    (hum_dec),
        .temp_int   (temp_int),
        .temp_dec   (temp_dec),
`ifdef DHT11_RESP_CHKERR_EN
        .chk_corrupt(chk_corrupt),
`endif
        .busy       (busy),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Counts consecutive falling-edge samples at level lvl; leaves the bench
    // on the first sample of the opposite level. Bounded at 400 clocks.
    task automatic count_run(input logic lvl, output int n);
        n = 0;
        while (dht_bus === lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic host_start(input int us);
        host_low = 1'b1;
        repeat (us * TD) @(posedge clk);
        @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic wait_ack(output bit ok);
        int n = 0;
        @(negedge clk);
        while (dht_bus !== 1'b0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = (dht_bus === 1'b0);
        if (!ok) check("ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_frame(input logic [7:0] hi, input logic [7:0] hd, input logic [7:0] ti,
                             input logic [7:0] tdd, input logic [39:0] exp, input string tag);
        bit ok;
        int n, bad_low, bad_high, fd0;
        logic [39:0] data;
        logic [39:0] expv;
        expv = exp;
        hum_int = hi; hum_dec = hd; temp_int = ti; temp_dec = tdd;
        host_low = 1'b1;
        repeat (250 * TD) @(posedge clk);
        @(negedge clk);
        check({tag, "_start_state"}, {60'd0, state_dbg}, 64'd1);
        host_low = 1'b0;
        fd0 = fd_cnt;
        wait_ack(ok);
        if (!ok) return;
        // Payload changes after capture must not reach the frame in flight.
        hum_int = ~hi; hum_dec = ~hd; temp_int = ~ti; temp_dec = ~tdd;
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        count_run(1'b0, n);
        check({tag, "_ack_low"}, n, 64'd160);
        count_run(1'b1, n);
        check({tag, "_ack_high"}, n, 64'd160);
        bad_low = 0; bad_high = 0; data = '0;
        for (int i = 0; i < 40; i++) begin
            count_run(1'b0, n);
            if (n != 100) bad_low++;
            count_run(1'b1, n);
            data = {data[38:0], (n > 96)};
            if (expv[39 - i] ? (n < 139 || n > 141) : (n < 51 || n > 53)) bad_high++;
        end
        check({tag, "_frame"}, data, expv);
        check({tag, "_bit_low_bad"}, bad_low, 64'd0);
        check({tag, "_bit_high_bad"}, bad_high, 64'd0);
        count_run(1'b0, n);
        check({tag, "_end_low"}, n, 64'd100);
        repeat (6) @(negedge clk);
        check({tag, "_frame_done_cnt"}, fd_cnt - fd0, 64'd1);
        check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        check({tag, "_state_after"}, {60'd0, state_dbg}, 64'd0);
    endtask

    initial begin
        bit ok;
        int n, busy_seen, drv_seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_frame_done", {63'd0, frame_done}, 64'd0);
        check("rst_state", {60'd0, state_dbg}, 64'd0);
        check("rst_bus", {63'd0, dht_bus}, 64'd1);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        run_frame(8'h32, 8'h00, 8'h19, 8'h00, 40'h32_00_19_00_4B, "f1");
        run_frame(8'h4B, 8'h05, 8'h16, 8'h03, 40'h4B_05_16_03_69, "f2");
        run_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 40'hFF_FF_FF_FF_FC, "f3");

        // Host low just under the threshold: no response.
        busy_seen = 0; drv_seen = 0;
        host_low = 1'b1;
        for (int i = 0; i < 199 * TD; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        host_low = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (dht_bus !== 1'b1) drv_seen++;
        end
        check("short_busy", busy_seen, 64'd0);
        check("short_bus", drv_seen, 64'd0);

        // Reset during BIT_HIGH of bit 12.
        hum_int = 8'h32; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h00;
        host_start(250);
        wait_ack(ok);
        if (ok) begin
            count_run(1'b0, n);
            count_run(1'b1, n);
            for (int i = 0; i < 12; i++) begin
                count_run(1'b0, n);
                count_run(1'b1, n);
            end
            count_run(1'b0, n);
            repeat (10) @(negedge clk);
            check("mid_pre_state", {60'd0, state_dbg}, 64'd6);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("mid_rst_state", {60'd0, state_dbg}, 64'd0);
            check("mid_rst_busy", {63'd0, busy}, 64'd0);
            check("mid_rst_bus", {63'd0, dht_bus}, 64'd1);
        end

        // Reset while the responder drives the ack low: line released next clock.
        repeat (10) @(negedge clk);
        host_start(250);
        wait_ack(ok);
        if (ok) begin
            repeat (5) @(negedge clk);
            check("ack_pre_bus", {63'd0, dht_bus}, 64'd0);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("ack_rst_bus", {63'd0, dht_bus}, 64'd1);
            check("ack_rst_state", {60'd0, state_dbg}, 64'd0);
        end
        repeat (10) @(negedge clk);

        run_frame(8'h32, 8'h00, 8'h19, 8'h00, 40'h32_00_19_00_4B, "f4");

`ifdef DHT11_RESP_CHKERR_EN
        chk_corrupt = 1'b1;
        run_frame(8'h32, 8'h00, 8'h19, 8'h00, 40'h32_00_19_00_4A, "f5");
        chk_corrupt = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dht11_responder.md
# dht11_responder

Synthesizable DHT11 sensor emulator: the responder end of the single-wire DHT11 protocol. It watches the open-drain bus for a host start pulse, then answers with the 80 µs/80 µs acknowledge and a 40-bit frame built from register inputs plus a computed checksum. It is used for on-FPGA loopback of `dht11_sensor` and as a self-checking bus model in benches, with no physical sensor attached.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: clock frequency; sets the 1 µs tick divider `TICK_DIV = CLK_FREQ_HZ/1_000_000`.
- `START_MIN_US`, 18000: minimum continuous host low, in µs, that is accepted as a start request.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `dht11_io  inout  1`: open-drain bus. The block only drives `0` or `z`; the pull-up is external.
- `hum_int, hum_dec, temp_int, temp_dec  in  8 each`: payload bytes.
- `busy  out  1`: high from start acceptance until the line is released after the frame.
- `frame_done  out  1`: one-cycle pulse when the trailing low ends.
- `state_dbg  out  4`: current FSM state encoding.

## Operation
- Bus input passes through a 2-FF synchronizer (`io_s`). The block drives low only while `drv_low=1`.
- FSM states, encoded 0–8:
  - IDLE(0): `drv_low=0`. Counts consecutive µs with `io_s=0`. Any high sample clears the count. Count ≥ START_MIN_US → HOST_LOW.
  - HOST_LOW(1): waits for `io_s=1`.
  - HOST_REL(2): waits 30 µs.
  - ACK_LOW(3): latches all four payload bytes and the checksum into a 40-bit shift register, then drives low for 80 µs.
  - ACK_HIGH(4): releases for 80 µs.
  - BIT_LOW(5): drives low for 50 µs.
  - BIT_HIGH(6): releases for 70 µs if the MSB is 1, or 26 µs if it is 0. Then shifts left. Goes to BIT_LOW until 40 bits have been sent, else END_LOW.
  - END_LOW(7): drives low for 50 µs, pulses `frame_done`.
  - RELEASE(8): `drv_low=0`. Waits for `io_s=1`, then IDLE.
- Frame order is MSB-first: hum_int, hum_dec, temp_int, temp_dec, chk.
- `chk = (hum_int+hum_dec+temp_int+temp_dec) mod 256`, using an 8-bit wrapping sum.
- Payload changes after ACK_LOW entry have no effect on the frame in flight.
- The host driving low during states 3–7 is ignored; timing continues unchanged.
- A host low shorter than START_MIN_US is ignored. `busy` stays 0.
- Reset mid-frame: the line is released on the cycle after `rst` is sampled high. All counters clear and the FSM returns to IDLE.

## Timing
- Reset values: `busy=0`, `frame_done=0`, `state_dbg=0`, `drv_low=0` (bus `z`).
- A phase of N µs lasts exactly N·TICK_DIV clocks; at 50 MHz, 80 µs = 4000 clocks.
- Phase counters restart on every state entry.
- Start detection latency: the synchronizer adds 2 clocks. HOST_LOW is entered within one tick after the START_MIN_US-th low µs.
- `busy` rises on HOST_LOW entry and falls on RELEASE→IDLE.
- `frame_done` is high for exactly one clock, on the END_LOW→RELEASE transition.
- Nominal frame length from host release: 30 + 160 + 40·50 + Σ(26|70) + 50 µs.

## Configuration
- `DHT11_RESP_CHKERR_EN` defined:
  - Adds input port `chk_corrupt in 1`, sampled at ACK_LOW entry.
  - When `chk_corrupt` is 1, the transmitted checksum is `chk ^ 8'h01`.
- Undefined: the port is absent and the checksum is always correct.

## Structure
- `dht11_pkg` holds:
  - state encodings 0–8;
  - µs constants: 30, 80, 50, 26, 70, 50;
  - bit count 40;
  - shared with `dht11_sensor`.
- One sub-module, `dht11_us_tick`: a free-running divider producing a 1-clock pulse every TICK_DIV clocks. It is synchronously reset by `rst`.

## Test plan
- Host low 20 ms then release, payload 0x32,0x00,0x19,0x00 → ack 80/80 µs, decoded frame 0x32_00_19_00_4B, one `frame_done` pulse.
- Payload 0x4B,0x05,0x16,0x03 → chk 0x69. High times of 70/26 µs (±1 clock) match the bit values.
- Payload 0xFF×4 → chk wraps to 0xFC.
- Host low 10 ms → no response, `busy` stays 0, bus stays `z`.
- `rst` asserted during BIT_HIGH of bit 12 → bus `z` next clock, `state_dbg=0`. A following 20 ms start yields a full correct frame.
- With `DHT11_RESP_CHKERR_EN` and `chk_corrupt=1`, payload 0x32,0x00,0x19,0x00 → chk 0x4A; `dht11_sensor` must flag the frame invalid.
